// File: rtl/irq_controller_if.sv
// Bus bundle between the interrupt controller and its environment:
// raw interrupt lines, configuration port and the pipeline request/ack path.
interface irq_controller_if #(
  parameter int IRQ_NUM = 4,
  parameter int CAUSE_W = 2
);
  logic [IRQ_NUM-1:0] irq_in;
  logic               cfg_wen;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_din;
  logic [31:0]        cfg_dout;
  logic               ir_ack;
  logic               eret;
  logic               ir_req;
  logic [CAUSE_W-1:0] ir_cause;
  logic [31:0]        ir_vector;
  logic               in_service;
  logic [IRQ_NUM-1:0] pending;

  modport master (
    output irq_in, cfg_wen, cfg_addr, cfg_din, ir_ack, eret,
    input  cfg_dout, ir_req, ir_cause, ir_vector, in_service, pending
  );

  modport slave (
    input  irq_in, cfg_wen, cfg_addr, cfg_din, ir_ack, eret,
    output cfg_dout, ir_req, ir_cause, ir_vector, in_service, pending
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-triggered, masked, fixed-priority interrupt controller with a
// request/acknowledge/ERET handshake toward the pipeline.
module irq_controller #(
  parameter int          IRQ_NUM      = 4,
  parameter int          CAUSE_W      = 2,
  parameter logic [31:0] VEC_STRIDE   = 32'h20,
  parameter logic [31:0] VEC_BASE_RST = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [1:0] A_MASK    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_VBASE   = 2'd3;

  state_t             r_state, w_next_state;
  logic [IRQ_NUM-1:0] r_irq_d;
  logic [IRQ_NUM-1:0] r_pending;
  logic [IRQ_NUM-1:0] r_mask;
  logic               r_ie;
  logic [31:0]        r_vbase;
  logic               r_ir_req;
  logic [CAUSE_W-1:0] r_ir_cause;
  logic               r_in_service;

  logic [IRQ_NUM-1:0] w_edge;
  logic [IRQ_NUM-1:0] w_eligible;
  logic [IRQ_NUM-1:0] w_clr;
  logic [CAUSE_W-1:0] w_winner;
  logic               w_set_req;
  logic               w_do_ack;
  logic               w_do_eret;

  assign w_edge     = bus.irq_in & ~r_irq_d;
  assign w_eligible = r_pending & r_mask;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_winner = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = CAUSE_W'(i);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_set_req    = 1'b0;
    w_do_ack     = 1'b0;
    w_do_eret    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_ie && (w_eligible != '0)) begin
          w_set_req    = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ir_ack) begin
          w_do_ack     = 1'b1;
          w_next_state = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (bus.eret) begin
          w_do_eret    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // A fresh edge is OR-ed in after clearing, so it wins over W1C and service clear.
  assign w_clr = ((bus.cfg_wen && bus.cfg_addr == A_PENDING) ? bus.cfg_din[IRQ_NUM-1:0] : '0)
               | (w_do_ack ? (IRQ_NUM'(1) << r_ir_cause) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_irq_d      <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_ie         <= 1'b0;
      r_vbase      <= VEC_BASE_RST;
      r_ir_req     <= 1'b0;
      r_ir_cause   <= '0;
      r_in_service <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state   <= w_next_state;
      r_irq_d   <= bus.irq_in;
      r_pending <= (r_pending & ~w_clr) | w_edge;

      if (bus.cfg_wen && bus.cfg_addr == A_MASK)  r_mask  <= bus.cfg_din[IRQ_NUM-1:0];
      if (bus.cfg_wen && bus.cfg_addr == A_VBASE) r_vbase <= {bus.cfg_din[31:2], 2'b00};

      // ERET re-enables unconditionally, overriding any IE write made during service.
      if (w_do_eret)                                    r_ie <= 1'b1;
      else if (w_do_ack)                                r_ie <= 1'b0;
      else if (bus.cfg_wen && bus.cfg_addr == A_STATUS) r_ie <= bus.cfg_din[0];

      if (w_set_req) begin
        r_ir_req   <= 1'b1;
        r_ir_cause <= w_winner;
      end
      if (w_do_ack) begin
        r_ir_req     <= 1'b0;
        r_in_service <= 1'b1;
      end
      if (w_do_eret) r_in_service <= 1'b0;
    end
  end

  always_comb begin
    bus.cfg_dout = '0;
    unique case (bus.cfg_addr)
      A_MASK:    bus.cfg_dout = 32'(r_mask);
      A_STATUS:  bus.cfg_dout = {30'd0, r_in_service, r_ie};
      A_PENDING: bus.cfg_dout = 32'(r_pending);
      A_VBASE:   bus.cfg_dout = r_vbase;
      default:   bus.cfg_dout = '0;
    endcase
  end

  assign bus.ir_req     = r_ir_req;
  assign bus.ir_cause   = r_ir_cause;
  assign bus.ir_vector  = r_vbase + 32'(r_ir_cause) * VEC_STRIDE;
  assign bus.in_service = r_in_service;
  assign bus.pending    = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller: entry, priority, masking,
// set/clear conflicts, level-held lines, stray handshakes and async reset.
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_req   = 0;

  irq_controller_if #(.IRQ_NUM(4), .CAUSE_W(2)) u_if ();

  irq_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    u_if.cfg_wen  = 1'b1;
    u_if.cfg_addr = addr;
    u_if.cfg_din  = data;
    tick();
    u_if.cfg_wen  = 1'b0;
    u_if.cfg_din  = '0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    u_if.cfg_addr = addr;
    #1;
    check(tag, u_if.cfg_dout, exp);
  endtask

  task automatic pulse_irq(input logic [3:0] lines);
    u_if.irq_in = lines;
    tick();
    u_if.irq_in = '0;
  endtask

  task automatic pulse_ack();
    u_if.ir_ack = 1'b1;
    tick();
    u_if.ir_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    u_if.eret = 1'b1;
    tick();
    u_if.eret = 1'b0;
  endtask

  initial begin
    u_if.irq_in   = '0;
    u_if.cfg_wen  = 1'b0;
    u_if.cfg_addr = '0;
    u_if.cfg_din  = '0;
    u_if.ir_ack   = 1'b0;
    u_if.eret     = 1'b0;

    // Reset state
    tick(2);
    check("rst_req",     32'(u_if.ir_req), 32'd0);
    check("rst_cause",   32'(u_if.ir_cause), 32'd0);
    check("rst_insvc",   32'(u_if.in_service), 32'd0);
    check("rst_pending", 32'(u_if.pending), 32'd0);
    check("rst_vector",  u_if.ir_vector, 32'h100);
    read_chk("rst_vbase", 2'd3, 32'h100);
    read_chk("rst_mask",  2'd0, 32'h0);
    rst = 1'b0;
    tick();

    // Basic entry
    cfg_write(2'd0, 32'h4);
    cfg_write(2'd1, 32'h1);
    read_chk("basic_status_ie", 2'd1, 32'h1);
    pulse_irq(4'b0100);
    check("basic_pending", 32'(u_if.pending), 32'h4);
    check("basic_req_early", 32'(u_if.ir_req), 32'd0);
    tick();
    check("basic_req", 32'(u_if.ir_req), 32'd1);
    check("basic_cause", 32'(u_if.ir_cause), 32'd2);
    check("basic_vector", u_if.ir_vector, 32'h140);
    pulse_ack();
    check("basic_ack_req", 32'(u_if.ir_req), 32'd0);
    check("basic_insvc", 32'(u_if.in_service), 32'd1);
    check("basic_pend_clr", 32'(u_if.pending), 32'd0);
    read_chk("basic_status_svc", 2'd1, 32'h2);
    check("basic_cause_held", 32'(u_if.ir_cause), 32'd2);
    pulse_eret();
    check("basic_eret_insvc", 32'(u_if.in_service), 32'd0);
    read_chk("basic_status_ret", 2'd1, 32'h1);

    // Priority and hold
    cfg_write(2'd0, 32'hF);
    pulse_irq(4'b1010);
    check("prio_pending", 32'(u_if.pending), 32'hA);
    tick();
    check("prio_req", 32'(u_if.ir_req), 32'd1);
    check("prio_cause", 32'(u_if.ir_cause), 32'd1);
    cfg_write(2'd0, 32'h0);
    tick(3);
    check("hold_req", 32'(u_if.ir_req), 32'd1);
    check("hold_cause", 32'(u_if.ir_cause), 32'd1);
    pulse_ack();
    check("hold_ack_req", 32'(u_if.ir_req), 32'd0);
    check("hold_pending", 32'(u_if.pending), 32'h8);
    cfg_write(2'd0, 32'hF);
    pulse_eret();
    check("second_req_not_yet", 32'(u_if.ir_req), 32'd0);
    tick();
    check("second_req", 32'(u_if.ir_req), 32'd1);
    check("second_cause", 32'(u_if.ir_cause), 32'd3);
    check("second_vector", u_if.ir_vector, 32'h160);
    pulse_ack();
    pulse_eret();

    // Masked / disabled
    cfg_write(2'd1, 32'h0);
    pulse_irq(4'b0001);
    tick(3);
    check("dis_no_req", 32'(u_if.ir_req), 32'd0);
    check("dis_pending", 32'(u_if.pending), 32'h1);
    cfg_write(2'd1, 32'h1);
    check("en_req_not_yet", 32'(u_if.ir_req), 32'd0);
    tick();
    check("en_req", 32'(u_if.ir_req), 32'd1);
    check("en_cause", 32'(u_if.ir_cause), 32'd0);
    pulse_ack();
    pulse_eret();
    cfg_write(2'd1, 32'h0);
    pulse_irq(4'b0001);
    check("w1c_pre", 32'(u_if.pending), 32'h1);
    cfg_write(2'd2, 32'h1);
    check("w1c_cleared", 32'(u_if.pending), 32'h0);
    tick(3);
    check("w1c_no_req", 32'(u_if.ir_req), 32'd0);

    // Conflict: edge beats W1C
    u_if.irq_in   = 4'b0001;
    u_if.cfg_wen  = 1'b1;
    u_if.cfg_addr = 2'd2;
    u_if.cfg_din  = 32'h1;
    tick();
    u_if.irq_in   = '0;
    u_if.cfg_wen  = 1'b0;
    u_if.cfg_din  = '0;
    check("conf_w1c_edge", 32'(u_if.pending), 32'h1);
    cfg_write(2'd1, 32'h1);
    tick();
    check("conf_req", 32'(u_if.ir_req), 32'd1);
    // Conflict: edge beats service clear
    u_if.irq_in = 4'b0001;
    u_if.ir_ack = 1'b1;
    tick();
    u_if.irq_in = '0;
    u_if.ir_ack = 1'b0;
    check("conf_ack_pending", 32'(u_if.pending), 32'h1);
    check("conf_ack_insvc", 32'(u_if.in_service), 32'd1);
    pulse_eret();
    check("conf_rereq_not_yet", 32'(u_if.ir_req), 32'd0);
    tick();
    check("conf_rereq", 32'(u_if.ir_req), 32'd1);
    check("conf_rereq_cause", 32'(u_if.ir_cause), 32'd0);
    pulse_ack();
    pulse_eret();

    // Level-held line produces exactly one request
    u_if.irq_in = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.ir_req === 1'b1) n_req++;
      u_if.ir_ack = u_if.ir_req;
      u_if.eret   = u_if.in_service;
    end
    u_if.irq_in = '0;
    u_if.ir_ack = 1'b0;
    u_if.eret   = 1'b0;
    tick(3);
    check("level_one_req", 32'(n_req), 32'd1);
    check("level_insvc", 32'(u_if.in_service), 32'd0);
    check("level_pending", 32'(u_if.pending), 32'h0);

    // Stray eret in IDLE
    pulse_eret();
    check("stray_eret_req", 32'(u_if.ir_req), 32'd0);
    check("stray_eret_insvc", 32'(u_if.in_service), 32'd0);
    read_chk("stray_eret_status", 2'd1, 32'h1);

    // Enter SERVICE on source 3, then a stray ack
    pulse_irq(4'b1000);
    tick();
    check("svc3_req", 32'(u_if.ir_req), 32'd1);
    check("svc3_cause", 32'(u_if.ir_cause), 32'd3);
    pulse_ack();
    pulse_ack();
    check("stray_ack_insvc", 32'(u_if.in_service), 32'd1);
    check("stray_ack_req", 32'(u_if.ir_req), 32'd0);
    check("stray_ack_cause", 32'(u_if.ir_cause), 32'd3);
    read_chk("stray_ack_status", 2'd1, 32'h2);
    cfg_write(2'd3, 32'h0000_2003);
    read_chk("vbase_align", 2'd3, 32'h2000);
    check("vbase_vector", u_if.ir_vector, 32'h2060);
    pulse_irq(4'b0010);
    check("svc_pending", 32'(u_if.pending), 32'h2);

    // Async reset mid-SERVICE, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_insvc", 32'(u_if.in_service), 32'd0);
    check("arst_req", 32'(u_if.ir_req), 32'd0);
    check("arst_pending", 32'(u_if.pending), 32'h0);
    read_chk("arst_vbase", 2'd3, 32'h100);
    check("arst_vector", u_if.ir_vector, 32'h100);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
